// File: rtl/ski_pkg.sv
// Shared widths, field positions, status codes and FSM encoding for the SKI
// reduction datapath.
package ski_pkg;

  localparam int NODE_W    = 65;
  localparam int CTX_W     = 95;
  localparam int RES_W     = 129;
  localparam int PAYLOAD_W = 63;

  localparam int NODE_TAG_HI = 64;
  localparam int NODE_TAG_LO = 63;
  localparam int CTX_TAG_HI  = 94;
  localparam int CTX_TAG_LO  = 93;

  localparam int RES_VALID  = 128;
  localparam int RES_TAG_HI = 127;
  localparam int RES_TAG_LO = 126;
  localparam int RES_A_HI   = 125;
  localparam int RES_A_LO   = 63;
  localparam int RES_B_HI   = 62;
  localparam int RES_B_LO   = 0;

  typedef enum logic [1:0] {
    STATUS_NORMAL = 2'b00,
    STATUS_LIMIT  = 2'b01,
    STATUS_ABORT  = 2'b10
  } statusE;

  typedef enum logic [2:0] {
    IDLE, RD0, RD1, LAT, CHECK, WR0, WR1, DONE
  } stateE;

endpackage

// File: rtl/ski_reduce_ctrl.sv
// Fetches a node pair from the heap, presents it to the external rewrite
// checker and writes matched results back until normal form, budget or abort.
module ski_reduce_ctrl
  import ski_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_STEPS = 1000
) (
  input  logic              system1000,
  input  logic              system1000_rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] ptr_i,
  input  logic [CTX_W-1:0]  ctx0_i,
  input  logic [CTX_W-1:0]  ctx1_i,
  input  logic              abort_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic [NODE_W-1:0] mem_wdata_o,
  input  logic [NODE_W-1:0] mem_rdata_i,
  output logic [NODE_W-1:0] chk_ww_o,
  output logic [NODE_W-1:0] chk_ww1_o,
  output logic [CTX_W-1:0]  chk_ww2_o,
  output logic [CTX_W-1:0]  chk_ww3_o,
  input  logic [RES_W-1:0]  chk_result_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        status_o,
  output logic [15:0]       steps_o
);

  stateE                state;
  logic [ADDR_W-1:0]    ptrReg;
  logic [PAYLOAD_W-1:0] resB;
  logic                 abortPending;

  logic [ADDR_W-1:0] ptrNext;
  logic              limitReached;
  logic [15:0]       stepsInc;

  assign ptrNext      = ptrReg + ADDR_W'(1);
  assign limitReached = (steps_o == 16'(MAX_STEPS));
  assign stepsInc     = (steps_o == 16'hFFFF) ? steps_o : steps_o + 16'd1;

  // Outputs are registered, so each transition also sets the strobes and
  // address that belong to the state being entered.
  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      state        <= IDLE;
      ptrReg       <= '0;
      resB         <= '0;
      abortPending <= 1'b0;
      mem_addr_o   <= '0;
      mem_re_o     <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_wdata_o  <= '0;
      chk_ww_o     <= '0;
      chk_ww1_o    <= '0;
      chk_ww2_o    <= '0;
      chk_ww3_o    <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      status_o     <= STATUS_NORMAL;
      steps_o      <= '0;
    end else begin
      mem_re_o <= 1'b0;
      mem_we_o <= 1'b0;
      done_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            ptrReg       <= ptr_i;
            chk_ww2_o    <= ctx0_i;
            chk_ww3_o    <= ctx1_i;
            steps_o      <= '0;
            abortPending <= 1'b0;
            busy_o       <= 1'b1;
            mem_re_o     <= 1'b1;
            mem_addr_o   <= ptr_i;
            state        <= RD0;
          end
        end
        RD0: begin
          if (abort_i) begin
            status_o <= STATUS_ABORT;
            done_o   <= 1'b1;
            state    <= DONE;
          end else begin
            mem_re_o   <= 1'b1;
            mem_addr_o <= ptrNext;
            state      <= RD1;
          end
        end
        RD1: begin
          chk_ww_o <= mem_rdata_i;
          if (abort_i) begin
            status_o <= STATUS_ABORT;
            done_o   <= 1'b1;
            state    <= DONE;
          end else begin
            state <= LAT;
          end
        end
        LAT: begin
          chk_ww1_o <= mem_rdata_i;
          if (abort_i) begin
            status_o <= STATUS_ABORT;
            done_o   <= 1'b1;
            state    <= DONE;
          end else begin
            state <= CHECK;
          end
        end
        CHECK: begin
          if (abort_i) begin
            status_o <= STATUS_ABORT;
            done_o   <= 1'b1;
            state    <= DONE;
          end else if (!chk_result_i[RES_VALID]) begin
            status_o <= STATUS_NORMAL;
            done_o   <= 1'b1;
            state    <= DONE;
          end else if (limitReached) begin
            status_o <= STATUS_LIMIT;
            done_o   <= 1'b1;
            state    <= DONE;
          end else begin
            resB        <= chk_result_i[RES_B_HI:RES_B_LO];
            mem_we_o    <= 1'b1;
            mem_addr_o  <= ptrReg;
            mem_wdata_o <= {chk_result_i[RES_TAG_HI:RES_TAG_LO],
                            chk_result_i[RES_A_HI:RES_A_LO]};
            state       <= WR0;
          end
        end
        // An abort seen here is deferred so the second word still lands.
        WR0: begin
          abortPending <= abort_i;
          mem_we_o     <= 1'b1;
          mem_addr_o   <= ptrNext;
          mem_wdata_o  <= {2'b00, resB};
          state        <= WR1;
        end
        WR1: begin
          steps_o      <= stepsInc;
          abortPending <= 1'b0;
          if (abort_i || abortPending) begin
            status_o <= STATUS_ABORT;
            done_o   <= 1'b1;
            state    <= DONE;
          end else begin
            mem_re_o   <= 1'b1;
            mem_addr_o <= ptrReg;
            state      <= RD0;
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
